// File: rtl/fpu_regfile.sv
// CP1 architectural register file: 32 x 32-bit FPRs plus FCSR, multi-lane write,
// combinational reads straight from storage (bypassing is handled downstream).
module fpu_regfile #(
  parameter int ISSUE_NUM = 2,
  parameter int RD_NUM    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_NUM-1:0][4:0]     raddr,
  output logic [RD_NUM-1:0][31:0]    rdata,
  input  logic [ISSUE_NUM-1:0]       we,
  input  logic [ISSUE_NUM-1:0][4:0]  waddr,
  input  logic [ISSUE_NUM-1:0][31:0] wdata,
  input  logic [ISSUE_NUM-1:0]       fcsr_we,
  input  logic [ISSUE_NUM-1:0][31:0] fcsr_wdata,
  output logic [31:0]                fcsr_o,
  output logic [7:0]                 fcc_o
);

  localparam logic [31:0] FcsrWriteMask = 32'hFF83_FFFF;

  logic [31:0] fpr_q [32];
  logic [31:0] fpr_d [32];
  logic [31:0] fcsr_q;
  logic [31:0] fcsr_d;

  // Lanes are walked in ascending order so the youngest (highest) lane wins collisions.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      fpr_d[i] = fpr_q[i];
    end
    fcsr_d = fcsr_q;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      if (we[j]) begin
        fpr_d[waddr[j]] = wdata[j];
      end
      if (fcsr_we[j]) begin
        fcsr_d = fcsr_wdata[j] & FcsrWriteMask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        fpr_q[i] <= '0;
      end
      fcsr_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        fpr_q[i] <= fpr_d[i];
      end
      fcsr_q <= fcsr_d;
    end
  end

  // Nothing but the read mux sits between storage and rdata.
  for (genvar r = 0; r < RD_NUM; r++) begin : g_read
    assign rdata[r] = fpr_q[raddr[r]];
  end

  assign fcsr_o = fcsr_q;
  assign fcc_o  = {fcsr_q[31:25], fcsr_q[23]};

endmodule
